// File: rtl/reduce_xor_sequencer_if.sv
// Stream bundle for the share recombiner: share beats in, recombined value out.
// Clock and reset stay outside the bundle as plain ports.
interface reduce_xor_sequencer_if #(
   parameter int LANES         = 2,
   parameter int ELEMENT_WIDTH = 8
);
   logic                             in_valid;
   logic                             out_ready;
   logic [LANES*ELEMENT_WIDTH-1:0]   in_shares;
   logic                             in_clear;
   logic                             out_valid;
   logic                             in_out_ready;
   logic [ELEMENT_WIDTH-1:0]         out_xor;
   logic                             out_busy;

   modport slave (
      input  in_valid, in_shares, in_clear, in_out_ready,
      output out_ready, out_valid, out_xor, out_busy
   );

   modport master (
      output in_valid, in_shares, in_clear, in_out_ready,
      input  out_ready, out_valid, out_xor, out_busy
   );
endinterface

// File: rtl/reduce_xor_sequencer.sv
// Recombines NUM_SHARES Boolean shares arriving LANES per beat; result is registered 1 cycle after the last beat.
// Backpressure: a pending unconsumed result drops out_ready and freezes the accumulation.
module reduce_xor_sequencer_fold #(
   parameter int LANES         = 2,
   parameter int ELEMENT_WIDTH = 8
) (
   input  logic [LANES*ELEMENT_WIDTH-1:0] lanes_i,
   output logic [ELEMENT_WIDTH-1:0]       xor_o
);
   always_comb begin
      xor_o = '0;
      for (int j = 0; j < LANES; j++) begin
         xor_o = xor_o ^ lanes_i[j*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
   end
endmodule

module reduce_xor_sequencer #(
   parameter int NUM_SHARES    = 5,
   parameter int ELEMENT_WIDTH = 8,
   parameter int LANES         = 2
) (
   input  logic                  in_clock,
   input  logic                  in_reset_n,
   reduce_xor_sequencer_if.slave s_if
);
   localparam int NUM_BEATS  = (NUM_SHARES + LANES - 1) / LANES;
   localparam int LAST_LANES = NUM_SHARES - (NUM_BEATS - 1) * LANES;
   localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [ELEMENT_WIDTH-1:0]       acc_q, acc_d;
   logic                           out_valid_q, out_valid_d;
   logic [ELEMENT_WIDTH-1:0]       out_xor_q, out_xor_d;

   logic                           last_beat;
   logic                           accept;
   logic                           consume;
   logic                           ready;
   logic [LANES*ELEMENT_WIDTH-1:0] masked_shares;
   logic [ELEMENT_WIDTH-1:0]       beat_xor;
   logic [ELEMENT_WIDTH-1:0]       acc_base;

   assign last_beat = (cnt_q == LAST_CNT);
   assign ready     = !out_valid_q || s_if.in_out_ready;
   assign accept    = s_if.in_valid && ready && !s_if.in_clear;
   assign consume   = out_valid_q && s_if.in_out_ready;
   assign acc_base  = (cnt_q == '0) ? '0 : acc_q;

   // Unused lanes of the final beat are zeroed before the fold so they cannot leak in.
   always_comb begin
      masked_shares = '0;
      for (int j = 0; j < LANES; j++) begin
         if (!last_beat || (j < LAST_LANES)) begin
            masked_shares[j*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
               s_if.in_shares[j*ELEMENT_WIDTH +: ELEMENT_WIDTH];
         end
      end
   end

   reduce_xor_sequencer_fold #(
      .LANES         (LANES),
      .ELEMENT_WIDTH (ELEMENT_WIDTH)
   ) u_fold (
      .lanes_i (masked_shares),
      .xor_o   (beat_xor)
   );

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_xor_d   = out_xor_q;
      if (consume) begin
         out_valid_d = 1'b0;
      end
      // Clear only aborts the partial value; a pending result is left alone.
      if (s_if.in_clear) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (accept) begin
         if (last_beat) begin
            out_xor_d   = acc_base ^ beat_xor;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
         end else begin
            acc_d = acc_base ^ beat_xor;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_xor_q   <= '0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_xor_q   <= out_xor_d;
      end
   end

   assign s_if.out_ready = ready;
   assign s_if.out_valid = out_valid_q;
   assign s_if.out_xor   = out_xor_q;
   assign s_if.out_busy  = (cnt_q != '0);
endmodule

// File: tb/tb_reduce_xor_sequencer.sv
// Directed bench: 5-share/2-lane instance driven from a vector table, plus a 3-share/3-lane single-beat instance.
module tb_reduce_xor_sequencer;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   reduce_xor_sequencer_if #(.LANES(2), .ELEMENT_WIDTH(8)) rif ();
   reduce_xor_sequencer_if #(.LANES(3), .ELEMENT_WIDTH(8)) rif3 ();

   reduce_xor_sequencer #(.NUM_SHARES(5), .ELEMENT_WIDTH(8), .LANES(2)) dut (
      .in_clock   (clk),
      .in_reset_n (rst_n),
      .s_if       (rif.slave)
   );

   reduce_xor_sequencer #(.NUM_SHARES(3), .ELEMENT_WIDTH(8), .LANES(3)) dut3 (
      .in_clock   (clk),
      .in_reset_n (rst_n),
      .s_if       (rif3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [15:0] sh;
      logic        clr;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [7:0]  e_x;
      logic        e_busy;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(input logic vld, input logic [15:0] sh, input logic clr,
                               input logic ordy, input logic e_rdy, input logic e_ov,
                               input logic [7:0] e_x, input logic e_busy);
      vec_t v;
      v.vld = vld; v.sh = sh; v.clr = clr; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_x = e_x; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Drive one beat at posedge+1, check out_ready before the edge, registered outputs after it.
   task automatic beat(input string nm, input logic vld, input logic [15:0] sh, input logic clr,
                       input logic ordy, input logic e_rdy, input logic e_ov,
                       input logic [7:0] e_x, input logic e_busy);
      rif.in_valid     = vld;
      rif.in_shares    = sh;
      rif.in_clear     = clr;
      rif.in_out_ready = ordy;
      #1;
      chk({nm, ".out_ready"}, 32'(rif.out_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk({nm, ".out_valid"}, 32'(rif.out_valid), 32'(e_ov));
      chk({nm, ".out_xor"},   32'(rif.out_xor),   32'(e_x));
      chk({nm, ".out_busy"},  32'(rif.out_busy),  32'(e_busy));
   endtask

   task automatic beat3(input string nm, input logic vld, input logic [23:0] sh, input logic ordy,
                        input logic e_rdy, input logic e_ov, input logic [7:0] e_x);
      rif3.in_valid     = vld;
      rif3.in_shares    = sh;
      rif3.in_clear     = 1'b0;
      rif3.in_out_ready = ordy;
      #1;
      chk({nm, ".out_ready"}, 32'(rif3.out_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk({nm, ".out_valid"}, 32'(rif3.out_valid), 32'(e_ov));
      chk({nm, ".out_xor"},   32'(rif3.out_xor),   32'(e_x));
      chk({nm, ".out_busy"},  32'(rif3.out_busy),  32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rif.in_valid = 1'b0;  rif.in_shares = '0;  rif.in_clear = 1'b0;  rif.in_out_ready = 1'b0;
      rif3.in_valid = 1'b0; rif3.in_shares = '0; rif3.in_clear = 1'b0; rif3.in_out_ready = 1'b0;

      // vld, shares, clr, ordy | out_ready, out_valid, out_xor, out_busy
      tbl[0]  = mk(1, 16'h1122, 0, 1,  1, 0, 8'h00, 1);
      tbl[1]  = mk(1, 16'h4488, 0, 1,  1, 0, 8'h00, 1);
      tbl[2]  = mk(1, 16'hAA0F, 0, 1,  1, 1, 8'hF0, 0);
      tbl[3]  = mk(0, 16'h0000, 0, 1,  1, 0, 8'hF0, 0);
      tbl[4]  = mk(1, 16'h1122, 0, 0,  1, 0, 8'hF0, 1);
      tbl[5]  = mk(1, 16'h4488, 0, 0,  1, 0, 8'hF0, 1);
      tbl[6]  = mk(1, 16'hAA0F, 0, 0,  1, 1, 8'hF0, 0);
      tbl[7]  = mk(1, 16'h0101, 0, 0,  0, 1, 8'hF0, 0);
      tbl[8]  = mk(1, 16'h0101, 0, 0,  0, 1, 8'hF0, 0);
      tbl[9]  = mk(1, 16'h0101, 0, 0,  0, 1, 8'hF0, 0);
      tbl[10] = mk(1, 16'h0101, 0, 0,  0, 1, 8'hF0, 0);
      tbl[11] = mk(1, 16'h0101, 0, 1,  1, 0, 8'hF0, 1);
      tbl[12] = mk(1, 16'h0101, 0, 1,  1, 0, 8'hF0, 1);
      tbl[13] = mk(1, 16'hFF01, 0, 1,  1, 1, 8'h01, 0);
      tbl[14] = mk(1, 16'h1122, 0, 1,  1, 0, 8'h01, 1);
      tbl[15] = mk(1, 16'h4488, 0, 1,  1, 0, 8'h01, 1);
      tbl[16] = mk(1, 16'hAA0F, 0, 1,  1, 1, 8'hF0, 0);
      tbl[17] = mk(1, 16'h0101, 0, 1,  1, 0, 8'hF0, 1);
      tbl[18] = mk(1, 16'h0101, 0, 1,  1, 0, 8'hF0, 1);
      tbl[19] = mk(1, 16'hFF01, 0, 1,  1, 1, 8'h01, 0);
      tbl[20] = mk(1, 16'h1122, 0, 1,  1, 0, 8'h01, 1);
      tbl[21] = mk(1, 16'h4488, 1, 1,  1, 0, 8'h01, 0);
      tbl[22] = mk(1, 16'h0201, 0, 1,  1, 0, 8'h01, 1);
      tbl[23] = mk(1, 16'h0804, 0, 1,  1, 0, 8'h01, 1);
      tbl[24] = mk(1, 16'h5510, 0, 1,  1, 1, 8'h1F, 0);
      tbl[25] = mk(0, 16'h0000, 1, 0,  0, 1, 8'h1F, 0);
      tbl[26] = mk(0, 16'h0000, 0, 1,  1, 0, 8'h1F, 0);

      #12;
      chk("rst.out_valid", 32'(rif.out_valid), 32'd0);
      chk("rst.out_xor",   32'(rif.out_xor),   32'd0);
      chk("rst.out_busy",  32'(rif.out_busy),  32'd0);
      chk("rst.out_ready", 32'(rif.out_ready), 32'd1);
      chk("rst3.out_valid", 32'(rif3.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         beat($sformatf("vec%0d", i), tbl[i].vld, tbl[i].sh, tbl[i].clr, tbl[i].ordy,
              tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_x, tbl[i].e_busy);
      end

      // Asynchronous reset between edges after two beats discards the partial value.
      beat("arst.b1", 1, 16'h0201, 0, 1,  1, 0, 8'h1F, 1);
      beat("arst.b2", 1, 16'h0804, 0, 1,  1, 0, 8'h1F, 1);
      rif.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.out_valid", 32'(rif.out_valid), 32'd0);
      chk("arst.out_busy",  32'(rif.out_busy),  32'd0);
      chk("arst.out_ready", 32'(rif.out_ready), 32'd1);
      chk("arst.out_xor",   32'(rif.out_xor),   32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat("post.b1", 1, 16'h1122, 0, 1,  1, 0, 8'h00, 1);
      beat("post.b2", 1, 16'h4488, 0, 1,  1, 0, 8'h00, 1);
      beat("post.b3", 1, 16'hAA0F, 0, 1,  1, 1, 8'hF0, 0);
      beat("post.idle", 0, 16'h0000, 0, 1,  1, 0, 8'hF0, 0);

      // Single-beat instance: result each accepted beat, consume and new result together.
      beat3("nb1.a",    1, 24'h3CF00F, 1,  1, 1, 8'hC3);
      beat3("nb1.b",    1, 24'h010204, 1,  1, 1, 8'h07);
      beat3("nb1.hold", 1, 24'h3CF00F, 0,  0, 1, 8'h07);
      beat3("nb1.drain", 0, 24'h000000, 1,  1, 0, 8'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
